// File: rtl/relu_guard_write_back_p.sv
// ReLU / requantise / write-back stage between the psum buffer and the
// feature-map and guard buffers. Each pixel is read once, rectified, shifted
// and saturated, then emitted as zero-skipped bytes behind a guard bitmap
// (8-bit mode) or as densely packed nibbles (4-bit mode).
module relu_guard_write_back_p #(
   parameter int PSUM_WIDTH = 16,
   parameter int NUM_CH     = 6,
   parameter int ADDR_W     = 8,
   parameter int SHIFT_W    = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                ctrl_valid,
   output logic                                ctrl_ready,
   output logic                                ctrl_finish,
   input  logic [7:0]                          w_num_i,
   input  logic [7:0]                          h_num_i,
   input  logic                                bit_mode_i,
   input  logic [SHIFT_W-1:0]                  shift_i,
   input  logic [NUM_CH-1:0][PSUM_WIDTH-1:0]   data_i,
   output logic                                rd_en,
   output logic [ADDR_W-1:0]                   addr_o,
   output logic [7:0]                          data_o,
   output logic                                data_o_valid,
   input  logic                                data_o_ready,
   output logic [NUM_CH-1:0]                   guard_o,
   output logic                                guard_o_valid,
   input  logic                                guard_o_ready
);
   // state | meaning
   // IDLE  | waiting for a layer command, ctrl_ready high
   // FETCH | read strobe for the current pixel address
   // LOAD  | psum word arrives, rectified/requantised values registered
   // GUARD | nonzero bitmap offered on the guard stream (8-bit mode)
   // EMIT  | activation bytes offered on the data stream
   // DONE  | one-cycle ctrl_finish pulse

   localparam int NUM_BYTES = (NUM_CH + 1) / 2;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_GUARD, S_EMIT, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic                          mode_q;
   logic [SHIFT_W-1:0]            shift_q;
   logic [15:0]                   pix_cnt;
   logic [ADDR_W-1:0]             pix_idx;
   logic [NUM_CH-1:0][7:0]        q;
   logic [NUM_CH-1:0]             g;
   logic [NUM_CH-1:0]             rem;
   logic [3:0]                    byte_k;

   logic [15:0]                   tile_px;
   logic [NUM_CH-1:0][PSUM_WIDTH-1:0] psum_pos;
   logic [NUM_CH-1:0][PSUM_WIDTH-1:0] psum_sh;
   logic [NUM_CH-1:0][7:0]        q_load;
   logic [NUM_CH-1:0]             g_load;
   logic [7:0]                    byte_8;
   logic [7:0]                    byte_4;
   logic [NUM_CH-1:0]             top;
   logic                          pix_end;

   assign tile_px = {8'd0, w_num_i} * {8'd0, h_num_i};
   assign addr_o  = pix_idx;

   // ReLU, logical right shift and mode-dependent saturation per channel
   always_comb begin
      psum_pos = '0;
      psum_sh  = '0;
      q_load   = '0;
      g_load   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         psum_pos[c] = data_i[c][PSUM_WIDTH-1] ? '0 : data_i[c];
         psum_sh[c]  = psum_pos[c] >> shift_q;
         if (mode_q)
            q_load[c] = (psum_sh[c] > PSUM_WIDTH'(15)) ? 8'd15 : {4'd0, psum_sh[c][3:0]};
         else
            q_load[c] = (psum_sh[c] > PSUM_WIDTH'(255)) ? 8'hFF : psum_sh[c][7:0];
         g_load[c] = (q_load[c] != 8'd0);
      end
   end

   // Byte selection: highest pending channel (8-bit) or nibble pair k (4-bit)
   always_comb begin
      byte_8 = '0;
      byte_4 = '0;
      top    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rem[c]) begin
            byte_8 = q[c];
            top    = '0;
            top[c] = 1'b1;
         end
         if (c == NUM_CH - 1 - 2 * int'(byte_k)) byte_4[7:4] = q[c][3:0];
         if (c == NUM_CH - 2 - 2 * int'(byte_k)) byte_4[3:0] = q[c][3:0];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_nxt     = state;
      ctrl_ready    = 1'b0;
      ctrl_finish   = 1'b0;
      rd_en         = 1'b0;
      data_o        = '0;
      data_o_valid  = 1'b0;
      guard_o       = '0;
      guard_o_valid = 1'b0;
      pix_end       = 1'b0;
      case (state)
         S_IDLE: begin
            ctrl_ready = 1'b1;
            if (ctrl_valid) state_nxt = (tile_px == 16'd0) ? S_DONE : S_FETCH;
         end
         S_FETCH: begin
            rd_en     = 1'b1;
            state_nxt = S_LOAD;
         end
         S_LOAD: state_nxt = mode_q ? S_EMIT : S_GUARD;
         S_GUARD: begin
            guard_o_valid = 1'b1;
            guard_o       = g;
            if (guard_o_ready) begin
               if (g != '0) state_nxt = S_EMIT;
               else         pix_end   = 1'b1;
            end
         end
         S_EMIT: begin
            data_o_valid = 1'b1;
            data_o       = mode_q ? byte_4 : byte_8;
            if (data_o_ready) begin
               if (mode_q) pix_end = (byte_k == 4'(NUM_BYTES - 1));
               else        pix_end = ((rem & ~top) == '0);
            end
         end
         S_DONE: begin
            ctrl_finish = 1'b1;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (pix_end) state_nxt = (pix_cnt == 16'd1) ? S_DONE : S_FETCH;
   end

   // Command latch, pixel bookkeeping and per-pixel activation registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= 1'b0;
         shift_q <= '0;
         pix_cnt <= '0;
         pix_idx <= '0;
         q       <= '0;
         g       <= '0;
         rem     <= '0;
         byte_k  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ctrl_valid) begin
                  mode_q  <= bit_mode_i;
                  shift_q <= shift_i;
                  pix_cnt <= tile_px;
                  pix_idx <= '0;
               end
            end
            S_LOAD: begin
               q      <= q_load;
               g      <= g_load;
               rem    <= g_load;
               byte_k <= '0;
            end
            S_EMIT: begin
               if (data_o_ready) begin
                  rem    <= rem & ~top;
                  byte_k <= byte_k + 4'd1;
               end
            end
            default: ;
         endcase
         if (pix_end) begin
            pix_cnt <= pix_cnt - 16'd1;
            pix_idx <= pix_idx + ADDR_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_relu_guard_write_back_p.sv
// Scoreboard bench for relu_guard_write_back_p with five channels and a
// 2-bit address so odd nibble packing and address wrap are both exercised.
module tb_relu_guard_write_back_p;
   localparam int PW = 16;
   localparam int NC = 5;
   localparam int AW = 2;

   typedef logic [NC-1:0][PW-1:0] word_t;

   logic clk = 1'b0;
   logic rst, ctrl_valid, ctrl_ready, ctrl_finish;
   logic [7:0] w_num_i, h_num_i;
   logic bit_mode_i;
   logic [3:0] shift_i;
   word_t data_i;
   logic rd_en;
   logic [AW-1:0] addr_o;
   logic [7:0] data_o;
   logic data_o_valid, data_o_ready;
   logic [NC-1:0] guard_o;
   logic guard_o_valid, guard_o_ready;

   relu_guard_write_back_p #(.PSUM_WIDTH(PW), .NUM_CH(NC), .ADDR_W(AW), .SHIFT_W(4)) dut (
      .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
      .ctrl_finish(ctrl_finish), .w_num_i(w_num_i), .h_num_i(h_num_i),
      .bit_mode_i(bit_mode_i), .shift_i(shift_i), .data_i(data_i), .rd_en(rd_en),
      .addr_o(addr_o), .data_o(data_o), .data_o_valid(data_o_valid),
      .data_o_ready(data_o_ready), .guard_o(guard_o), .guard_o_valid(guard_o_valid),
      .guard_o_ready(guard_o_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   word_t mem [4];
   int exp_addr[$];
   int exp_guard[$];
   int exp_data[$];

   // Junk on the psum bus outside the load cycle: large positive, never zero
   word_t junk;
   logic rd_seen = 1'b0;
   logic [AW-1:0] rd_addr = '0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic err(input string name);
      n_errors++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
   endtask

   function automatic word_t pk(input int a4, input int a3, input int a2, input int a1, input int a0);
      word_t r;
      r[4] = 16'(a4); r[3] = 16'(a3); r[2] = 16'(a2); r[1] = 16'(a1); r[0] = 16'(a0);
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Psum buffer model with one cycle of read latency
   always @(negedge clk) begin
      rd_seen = rd_en;
      rd_addr = addr_o;
   end
   always @(posedge clk) begin
      #1;
      data_i = rd_seen ? mem[rd_addr] : junk;
   end

   // Monitor: pops the scoreboard on every handshake and read strobe
   logic stall_d = 1'b0, stall_g = 1'b0;
   logic [7:0] held_d;
   logic [NC-1:0] held_g;
   always @(negedge clk) begin
      if (rst) begin
         stall_d = 1'b0;
         stall_g = 1'b0;
      end else begin
         chk("both_valid", int'(data_o_valid & guard_o_valid), 0);
         if (stall_d) begin
            chk("stall_data_valid", int'(data_o_valid), 1);
            chk("stall_data_value", int'(data_o), int'(held_d));
         end
         if (stall_g) begin
            chk("stall_guard_valid", int'(guard_o_valid), 1);
            chk("stall_guard_value", int'(guard_o), int'(held_g));
         end
         stall_d = data_o_valid && !data_o_ready;
         stall_g = guard_o_valid && !guard_o_ready;
         held_d  = data_o;
         held_g  = guard_o;
         if (rd_en) begin
            if (exp_addr.size() == 0) err("unexpected_read");
            else chk("addr", int'(addr_o), exp_addr.pop_front());
         end
         if (guard_o_valid && guard_o_ready) begin
            if (exp_guard.size() == 0) err("unexpected_guard");
            else chk("guard", int'(guard_o), exp_guard.pop_front());
         end
         if (data_o_valid && data_o_ready) begin
            if (exp_data.size() == 0) err("unexpected_data");
            else chk("data", int'(data_o), exp_data.pop_front());
         end
      end
   end

   task automatic start_cmd(input int w, input int h, input logic mode, input int sh);
      int n = 0;
      while (!ctrl_ready && n < 100) begin tick; n++; end
      w_num_i = 8'(w); h_num_i = 8'(h); bit_mode_i = mode; shift_i = 4'(sh);
      ctrl_valid = 1'b1;
      tick;
      ctrl_valid = 1'b0;
   endtask

   // Returns cycles from acceptance edge T to the cycle showing ctrl_finish
   task automatic wait_finish(output int lat);
      lat = 1;
      while (!ctrl_finish && lat < 500) begin tick; lat++; end
      if (!ctrl_finish) err("finish_timeout");
      tick;
      chk("finish_one_cycle", int'(ctrl_finish), 0);
      chk("ready_after_done", int'(ctrl_ready), 1);
   endtask

   task automatic run_cmd(input string name, input int w, input int h, input logic mode,
                          input int sh, input int exp_lat);
      int lat;
      start_cmd(w, h, mode, sh);
      wait_finish(lat);
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_addr_drained"}, exp_addr.size(), 0);
      chk({name, "_guard_drained"}, exp_guard.size(), 0);
      chk({name, "_data_drained"}, exp_data.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_ctrl_ready"}, int'(ctrl_ready), 1);
      chk({name, "_ctrl_finish"}, int'(ctrl_finish), 0);
      chk({name, "_rd_en"}, int'(rd_en), 0);
      chk({name, "_addr_o"}, int'(addr_o), 0);
      chk({name, "_data_o"}, int'(data_o), 0);
      chk({name, "_data_valid"}, int'(data_o_valid), 0);
      chk({name, "_guard_o"}, int'(guard_o), 0);
      chk({name, "_guard_valid"}, int'(guard_o_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not terminate");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int stall_rd;
      for (int c = 0; c < NC; c++) junk[c] = 16'h7FFF;
      data_i = junk;
      rst = 1'b1; ctrl_valid = 1'b0; w_num_i = '0; h_num_i = '0;
      bit_mode_i = 1'b0; shift_i = '0; data_o_ready = 1'b1; guard_o_ready = 1'b1;
      for (int i = 0; i < 4; i++) mem[i] = '0;
      repeat (3) tick;
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick;

      // Zero-skip, no stall: {5,-3,300,7,0} -> guard 10110, bytes 5,255,7
      mem[0] = pk(5, -3, 300, 7, 0);
      exp_addr.push_back(0);
      exp_guard.push_back('b10110);
      exp_data.push_back(5); exp_data.push_back(255); exp_data.push_back(7);
      run_cmd("zero_skip", 1, 1, 1'b0, 0, 7);

      // 4-bit, shift 2: {64,8,-1,20,3} -> {15,2,0,5,0}; bytes {q4,q3},{q2,q1},{q0,0}
      mem[0] = pk(64, 8, -1, 20, 3);
      exp_addr.push_back(0);
      exp_data.push_back('hF2); exp_data.push_back('h05); exp_data.push_back('h00);
      run_cmd("dense4", 1, 1, 1'b1, 2, 6);

      // All-negative pixels: two zero guards, no data
      mem[0] = pk(-1, -2, -100, -32768, -5);
      mem[1] = pk(-7, -7, -1, -300, -2);
      exp_addr.push_back(0); exp_addr.push_back(1);
      exp_guard.push_back(0); exp_guard.push_back(0);
      run_cmd("all_zero", 2, 1, 1'b0, 0, 7);

      // Zero-size tile: finish at T+1, no read
      run_cmd("zero_tile", 0, 3, 1'b0, 0, 1);

      // Address wrap with a 2-bit address, 5x1 tile in 4-bit mode
      mem[0] = pk(1, 2, 3, 4, 5);
      mem[1] = pk(0, 0, 0, 0, 0);
      mem[2] = pk(20, -4, 15, 16, 6);
      mem[3] = pk(7, 7, 7, 7, 7);
      exp_addr = '{0, 1, 2, 3, 0};
      exp_data = '{'h12, 'h34, 'h50, 'h00, 'h00, 'h00, 'hF0, 'hFF, 'h60,
                   'h77, 'h77, 'h70, 'h12, 'h34, 'h50};
      run_cmd("wrap", 5, 1, 1'b1, 0, 26);

      // Backpressure mid-pixel: ready low for 5 cycles after the first byte
      mem[0] = pk(1, 2, 3, 4, 5);
      mem[1] = pk(0, 0, 0, 0, 9);
      exp_addr = '{0, 1};
      exp_guard = '{'b11111, 'b00001};
      exp_data = '{1, 2, 3, 4, 5, 9};
      start_cmd(2, 1, 1'b0, 0);
      n = 0;
      while (!data_o_valid && n < 50) begin tick; n++; end
      chk("bp_first_valid", int'(data_o_valid), 1);
      tick;
      data_o_ready = 1'b0;
      stall_rd = 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (rd_en) stall_rd++;
      end
      data_o_ready = 1'b1;
      chk("bp_no_early_read", stall_rd, 0);
      wait_finish(n);
      chk("bp_addr_drained", exp_addr.size(), 0);
      chk("bp_data_drained", exp_data.size(), 0);

      // Reset during EMIT, then a fresh command completes normally
      mem[0] = pk(9, 9, 9, 9, 9);
      exp_addr = '{0};
      exp_guard = '{'b11111};
      exp_data = '{9, 9, 9, 9, 9};
      start_cmd(1, 1, 1'b0, 0);
      n = 0;
      while (!data_o_valid && n < 50) begin tick; n++; end
      chk("rst_reached_emit", int'(data_o_valid), 1);
      rst = 1'b1;
      tick;
      chk_reset_outputs("mid_reset");
      rst = 1'b0;
      exp_addr.delete(); exp_guard.delete(); exp_data.delete();
      tick;
      mem[0] = pk(5, -3, 300, 7, 0);
      exp_addr.push_back(0);
      exp_guard.push_back('b10110);
      exp_data.push_back(5); exp_data.push_back(255); exp_data.push_back(7);
      run_cmd("after_reset", 1, 1, 1'b0, 0, 7);

      repeat (2) tick;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
